// File: rtl/count_monitor_if.sv
// count_monitor_if
// Groups the sample stream and the monitor results of count_monitor.
//   in_cnt    : observed 4-bit count value
//   in_vld    : in_cnt is meaningful on this edge
//   locked    : monitor is tracking the sequence
//   err_pulse : one-cycle pulse per mismatch while locked
//   err_cnt   : saturating count of mismatches while locked
//   wrap_cnt  : saturating count of correct 15->0 wraps while locked
//   state     : current tracking state (HUNT=0, SYNC=1, LOCKED=2), for observation
// Handshake: there is no back-pressure. A sample is taken on every rising edge
// where in_vld=1; the results of that sample are visible one clock later.
interface count_monitor_if;
    logic [3:0] in_cnt;
    logic       in_vld;
    logic       locked;
    logic       err_pulse;
    logic [7:0] err_cnt;
    logic [7:0] wrap_cnt;
    logic [1:0] state;

    modport master (
        output in_cnt, in_vld,
        input  locked, err_pulse, err_cnt, wrap_cnt, state
    );

    modport slave (
        input  in_cnt, in_vld,
        output locked, err_pulse, err_cnt, wrap_cnt, state
    );
endinterface

// File: rtl/count_monitor.sv
// count_monitor
// Watches the output of a free-running 4-bit up-counter and reports whether it
// is counting correctly. After LOCK_N consecutive correct increments the
// monitor locks; while locked every mismatch is pulsed and counted, correct
// 15->0 wraps are counted, and LOSE_N consecutive mismatches drop back to SYNC.
// Every valid sample becomes the new reference, so the monitor follows a
// counter that has jumped to a new value.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : count_monitor_if.slave (in_cnt/in_vld in, results and state out)
module count_monitor #(
    parameter int LOCK_N = 4,
    parameter int LOSE_N = 2
) (
    input  logic            clk,
    input  logic            rst,
    count_monitor_if.slave  bus
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_V = 4'(LOCK_N);
    localparam logic [3:0] LOSE_V = 4'(LOSE_N);

    state_t     state;
    logic [3:0] prev;
    logic [3:0] good_run;
    logic [3:0] miss_run;
    logic       locked;
    logic       err_pulse;
    logic [7:0] err_cnt;
    logic [7:0] wrap_cnt;

    logic [3:0] exp_val;
    logic [3:0] good_nxt;
    logic [3:0] miss_nxt;
    logic       match;
    logic       wrap;

    // 4-bit addition wraps naturally, so 15 is followed by 0.
    assign exp_val  = prev + 4'd1;
    assign match    = (bus.in_cnt == exp_val);
    assign wrap     = (prev == 4'd15) && (bus.in_cnt == 4'd0);
    assign good_nxt = good_run + 4'd1;
    assign miss_nxt = miss_run + 4'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= HUNT;
            prev      <= 4'd0;
            good_run  <= 4'd0;
            miss_run  <= 4'd0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_cnt   <= 8'd0;
            wrap_cnt  <= 8'd0;
        end else begin
            err_pulse <= 1'b0;
            if (bus.in_vld) begin
                // Every sample becomes the new reference, mismatches included.
                prev <= bus.in_cnt;
                case (state)
                    HUNT: begin
                        good_run <= 4'd0;
                        state    <= SYNC;
                    end
                    SYNC: begin
                        if (match) begin
                            good_run <= good_nxt;
                            if (good_nxt == LOCK_V) begin
                                state    <= LOCKED;
                                locked   <= 1'b1;
                                miss_run <= 4'd0;
                            end
                        end else begin
                            good_run <= 4'd0;
                        end
                    end
                    LOCKED: begin
                        if (match) begin
                            miss_run <= 4'd0;
                            if (wrap && (wrap_cnt != 8'hFF)) begin
                                wrap_cnt <= wrap_cnt + 8'd1;
                            end
                        end else begin
                            // The mismatch that drops lock is still reported.
                            err_pulse <= 1'b1;
                            if (err_cnt != 8'hFF) begin
                                err_cnt <= err_cnt + 8'd1;
                            end
                            if (miss_nxt == LOSE_V) begin
                                state    <= SYNC;
                                locked   <= 1'b0;
                                good_run <= 4'd0;
                                miss_run <= 4'd0;
                            end else begin
                                miss_run <= miss_nxt;
                            end
                        end
                    end
                    default: begin
                        state  <= HUNT;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.locked    = locked;
    assign bus.err_pulse = err_pulse;
    assign bus.err_cnt   = err_cnt;
    assign bus.wrap_cnt  = wrap_cnt;
    assign bus.state     = state;

endmodule

// File: tb/tb_count_monitor.sv
// tb_count_monitor
// Self-checking bench for count_monitor (LOCK_N=4, LOSE_N=2). Each driven
// sample is applied to a behavioural model; the model's result is queued and
// compared against the DUT one clock later. Scenario tasks add targeted checks
// with fixed expected values.
module tb_count_monitor;

    localparam int LOCK_N = 4;
    localparam int LOSE_N = 2;
    localparam int W = 18;  // {locked, err_pulse, err_cnt, wrap_cnt}

    logic clk;
    logic rst;
    count_monitor_if bus ();

    count_monitor #(.LOCK_N(LOCK_N), .LOSE_N(LOSE_N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int         m_mode;   // 0 hunting, 1 syncing, 2 locked
    int         m_prev;
    int         m_good;
    int         m_miss;
    int         m_err;
    int         m_wrap;
    logic       m_pulse;

    task automatic model_reset();
        m_mode = 0; m_prev = 0; m_good = 0; m_miss = 0;
        m_err = 0; m_wrap = 0; m_pulse = 1'b0;
    endtask

    task automatic model_step(input logic vld, input int cnt);
        bit is_next;
        m_pulse = 1'b0;
        if (vld) begin
            is_next = (cnt == ((m_prev + 1) % 16));
            if (m_mode == 0) begin
                m_mode = 1;
                m_good = 0;
            end else if (m_mode == 1) begin
                if (is_next) begin
                    m_good++;
                    if (m_good == LOCK_N) begin
                        m_mode = 2;
                        m_miss = 0;
                    end
                end else begin
                    m_good = 0;
                end
            end else begin
                if (is_next) begin
                    m_miss = 0;
                    if (m_prev == 15 && m_wrap < 255) m_wrap++;
                end else begin
                    m_pulse = 1'b1;
                    if (m_err < 255) m_err++;
                    m_miss++;
                    if (m_miss == LOSE_N) begin
                        m_mode = 1;
                        m_good = 0;
                        m_miss = 0;
                    end
                end
            end
            m_prev = cnt;
        end
    endtask

    // ---------------- driver ----------------
    // Applies one sample at the falling edge, queues the model's prediction,
    // and returns shortly after the rising edge that consumed it.
    task automatic drive(input logic vld, input int cnt);
        @(negedge clk);
        bus.in_vld = vld;
        bus.in_cnt = 4'(cnt);
        model_step(vld, cnt);
        exp_q.push_back({(m_mode == 2), m_pulse, 8'(m_err), 8'(m_wrap)});
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.in_vld = 1'b0;
        exp_q.delete();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic acquire(input int start);
        for (int i = 0; i <= LOCK_N; i++) drive(1'b1, (start + i) % 16);
    endtask

    // ---------------- scoreboard ----------------
    always @(posedge clk) begin
        logic [W-1:0] exp_v;
        logic [W-1:0] act_v;
        #1;
        if (!rst && exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            act_v = {bus.locked, bus.err_pulse, bus.err_cnt, bus.wrap_cnt};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL scoreboard t=%0t got lk=%b ep=%b ec=%0d wc=%0d want lk=%b ep=%b ec=%0d wc=%0d",
                         $time, act_v[17], act_v[16], act_v[15:8], act_v[7:0],
                         exp_v[17], exp_v[16], exp_v[15:8], exp_v[7:0]);
            end
        end
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #2;  // before the first rising edge
        checks++;
        if ({bus.locked, bus.err_pulse, bus.err_cnt, bus.wrap_cnt} !== 18'd0) begin
            errors++;
            $display("FAIL reset_state got lk=%b ep=%b ec=%0d wc=%0d want all 0",
                     bus.locked, bus.err_pulse, bus.err_cnt, bus.wrap_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_lock();
        do_reset();
        for (int i = 0; i < LOCK_N; i++) begin
            drive(1'b1, i);
            checks++;
            if (bus.locked !== 1'b0) begin
                errors++;
                $display("FAIL lock_early sample=%0d got locked=%b want 0", i, bus.locked);
            end
        end
        drive(1'b1, LOCK_N);
        checks++;
        if (bus.locked !== 1'b1) begin
            errors++;
            $display("FAIL lock_acquire got locked=%b want 1", bus.locked);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        acquire(10);  // 10..14, prev=14
        drive(1'b1, 15);
        drive(1'b1, 0);
        drive(1'b1, 1);
        checks++;
        if (bus.wrap_cnt !== 8'd1 || bus.err_cnt !== 8'd0 || bus.locked !== 1'b1) begin
            errors++;
            $display("FAIL wrap got wc=%0d ec=%0d lk=%b want wc=1 ec=0 lk=1",
                     bus.wrap_cnt, bus.err_cnt, bus.locked);
        end
    endtask

    task automatic test_single_error();
        do_reset();
        acquire(0);   // prev=4
        drive(1'b1, 5);
        drive(1'b1, 9);
        checks++;
        if (bus.err_pulse !== 1'b1 || bus.err_cnt !== 8'd1 || bus.locked !== 1'b1) begin
            errors++;
            $display("FAIL single_err got ep=%b ec=%0d lk=%b want ep=1 ec=1 lk=1",
                     bus.err_pulse, bus.err_cnt, bus.locked);
        end
        drive(1'b0, 3);  // idle edge holds everything, pulse drops
        checks++;
        if (bus.err_pulse !== 1'b0 || bus.err_cnt !== 8'd1) begin
            errors++;
            $display("FAIL idle_hold got ep=%b ec=%0d want ep=0 ec=1", bus.err_pulse, bus.err_cnt);
        end
        drive(1'b1, 10);
        // A fresh single mismatch must not drop lock if 10 cleared miss_run.
        drive(1'b1, 3);
        checks++;
        if (bus.locked !== 1'b1 || bus.err_cnt !== 8'd2) begin
            errors++;
            $display("FAIL match_clears_miss got lk=%b ec=%0d want lk=1 ec=2", bus.locked, bus.err_cnt);
        end
    endtask

    task automatic test_lose_lock();
        do_reset();
        acquire(0);
        drive(1'b1, 5);
        drive(1'b1, 9);
        drive(1'b1, 9);  // repeat counts as mismatch
        checks++;
        if (bus.err_cnt !== 8'd2 || bus.locked !== 1'b0 || bus.err_pulse !== 1'b1) begin
            errors++;
            $display("FAIL lose_lock got ec=%0d lk=%b ep=%b want ec=2 lk=0 ep=1",
                     bus.err_cnt, bus.locked, bus.err_pulse);
        end
        drive(1'b1, 10);
        drive(1'b1, 11);
        drive(1'b1, 12);
        checks++;
        if (bus.locked !== 1'b0) begin
            errors++;
            $display("FAIL relock_early got lk=%b want 0", bus.locked);
        end
        drive(1'b1, 13);
        checks++;
        if (bus.locked !== 1'b1 || bus.err_cnt !== 8'd2) begin
            errors++;
            $display("FAIL relock got lk=%b ec=%0d want lk=1 ec=2", bus.locked, bus.err_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int v;
        do_reset();
        v = 0;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 9) == 0) v = $urandom_range(0, 15);
            else if ($urandom_range(0, 3) != 0) v = (v + 1) % 16;
            drive(1'($urandom_range(0, 5) != 0), v);
        end
    endtask

    task automatic test_saturation_reset();
        int p;
        do_reset();
        acquire(0);
        p = 4;
        for (int i = 0; i < 300; i++) begin
            p = (p + 2) % 16;
            drive(1'b1, p);        // mismatch
            p = (p + 1) % 16;
            drive(1'b1, p);        // match, clears miss_run
        end
        checks++;
        if (bus.err_cnt !== 8'd255 || bus.locked !== 1'b1 || bus.wrap_cnt !== 8'(m_wrap)) begin
            errors++;
            $display("FAIL saturate got ec=%0d lk=%b wc=%0d want ec=255 lk=1 wc=%0d",
                     bus.err_cnt, bus.locked, bus.wrap_cnt, m_wrap);
        end
        // Pulse reset between edges and look before the next rising edge.
        drive(1'b1, 0);            // mismatch so err_pulse is high now
        rst = 1'b1;
        exp_q.delete();
        model_reset();
        #1;
        checks++;
        if ({bus.locked, bus.err_pulse, bus.err_cnt, bus.wrap_cnt, bus.state} !== 20'd0) begin
            errors++;
            $display("FAIL async_reset got lk=%b ep=%b ec=%0d wc=%0d st=%0d want all 0",
                     bus.locked, bus.err_pulse, bus.err_cnt, bus.wrap_cnt, bus.state);
        end
        bus.in_vld = 1'b1;         // ignored while in reset
        @(posedge clk);
        #1;
        checks++;
        if (bus.state !== 2'd0) begin
            errors++;
            $display("FAIL reset_ignores_input got st=%0d want 0", bus.state);
        end
        @(negedge clk);
        bus.in_vld = 1'b0;
        rst = 1'b0;
        drive(1'b1, 7);            // first sample after reset is a HUNT sample
        checks++;
        if (bus.state !== 2'd1 || bus.locked !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_hunt got st=%0d lk=%b want st=1 lk=0", bus.state, bus.locked);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.in_vld = 1'b0;
        bus.in_cnt = 4'd0;
        model_reset();
        test_reset();
        test_lock();
        test_wrap();
        test_single_error();
        test_lose_lock();
        test_back_to_back();
        test_saturation_reset();
        drive(1'b0, 0);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
